// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Purpose:
//   Port 0 (execute stage) and port 1 (address-generation / auxiliary unit)
//   share a single combinational ALU. One request is granted per cycle, and
//   the granted operands drive the ALU. The ALU result is registered into a
//   one-entry response slot per port and is visible one cycle after acceptance.
//
// Ports:
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   reqN_valid/ready               request handshake, N = 0/1
//   reqN_op/a/b                    ALU select and operands for port N
//   rspN_valid/ready/data          response handshake and registered result
//   alu_sel/alu_a/alu_b            drive to the shared ALU
//   alu_result                     combinational result from the shared ALU

module alu_arbiter #(
  parameter int         DATAW   = 32,
  parameter logic [3:0] NOP_SEL = 4'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [DATAW-1:0] req0_a,
  input  logic [DATAW-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [DATAW-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [DATAW-1:0] req1_a,
  input  logic [DATAW-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [DATAW-1:0] rsp1_data,
  output logic [3:0]       alu_sel,
  output logic [DATAW-1:0] alu_a,
  output logic [DATAW-1:0] alu_b,
  input  logic [DATAW-1:0] alu_result
);

  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [DATAW-1:0] r_rsp0_data;
  logic [DATAW-1:0] r_rsp1_data;
  // Port that won the most recent grant; reset to 1 so port 0 wins first.
  logic             r_last_grant;

  logic w_free0;
  logic w_free1;
  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // A slot can be refilled in the same cycle it is drained.
  assign w_free0 = !r_rsp0_valid || rsp0_ready;
  assign w_free1 = !r_rsp1_valid || rsp1_ready;
  assign w_elig0 = req0_valid && w_free0;
  assign w_elig1 = req1_valid && w_free1;

  // Under contention the port that did not win last time is granted.
  assign w_grant0 = w_elig0 && (!w_elig1 || r_last_grant);
  assign w_grant1 = w_elig1 && (!w_elig0 || !r_last_grant);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    alu_sel = NOP_SEL;
    alu_a   = '0;
    alu_b   = '0;
    if (w_grant0) begin
      alu_sel = req0_op;
      alu_a   = req0_a;
      alu_b   = req0_b;
    end else if (w_grant1) begin
      alu_sel = req1_op;
      alu_a   = req1_a;
      alu_b   = req1_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_grant0) begin
        r_rsp0_data  <= alu_result;
        r_rsp0_valid <= 1'b1;
      end else if (r_rsp0_valid && rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end

      if (w_grant1) begin
        r_rsp1_data  <= alu_result;
        r_rsp1_valid <= 1'b1;
      end else if (r_rsp1_valid && rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end

      // Idle cycles leave the round-robin pointer untouched.
      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [3:0]  req0_op, req1_op, alu_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt0;
  int cnt1;

  alu_arbiter #(.DATAW(32), .NOP_SEL(4'd10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      4'd0:  alu_result = alu_a + alu_b;
      4'd1:  alu_result = alu_a - alu_b;
      4'd2:  alu_result = alu_a << alu_b[4:0];
      4'd3:  alu_result = alu_a >> alu_b[4:0];
      4'd4:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd5:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd6:  alu_result = {31'd0, alu_a < alu_b};
      4'd7:  alu_result = alu_a ^ alu_b;
      4'd8:  alu_result = alu_a | alu_b;
      4'd9:  alu_result = alu_a & alu_b;
      4'd10: alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_rsp0_valid", rsp0_valid, 32'd0);
    check("reset_rsp1_valid", rsp1_valid, 32'd0);
    check("reset_rsp0_data", rsp0_data, 32'd0);
    check("reset_rsp1_data", rsp1_data, 32'd0);

    // Single op
    drive0(1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    check("single_req0_ready", req0_ready, 32'd1);
    check("single_alu_sel", alu_sel, 32'd0);
    tick();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("single_rsp0_valid", rsp0_valid, 32'd1);
    check("single_rsp0_data", rsp0_data, 32'd12);

    // Contention after reset (last grant was port 0 before reset)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1'b1, 4'd1, 32'd10, 32'd3);
    drive1(1'b1, 4'd2, 32'd1, 32'd4);
    #1;
    check("cont_c0_req0_ready", req0_ready, 32'd1);
    check("cont_c0_req1_ready", req1_ready, 32'd0);
    tick();
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("cont_c1_rsp0_data", rsp0_data, 32'd7);
    check("cont_c1_req1_ready", req1_ready, 32'd1);
    tick();
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("cont_c2_rsp1_data", rsp1_data, 32'd16);
    check("cont_c2_rsp1_valid", rsp1_valid, 32'd1);
    check("cont_c2_rsp0_drained", rsp0_valid, 32'd0);

    // Alternation: last grant is port 1, so port 0 leads
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 4'd0, i, 32'd1);
      drive1(1'b1, 4'd0, i, 32'd100);
      #1;
      check($sformatf("alt%0d_req0_ready", i), req0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("alt%0d_req1_ready", i), req1_ready, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (req0_ready) cnt0++;
      if (req1_ready) cnt1++;
      tick();
      if (i % 2 == 0) check($sformatf("alt%0d_rsp0_data", i), rsp0_data, i + 1);
      else            check($sformatf("alt%0d_rsp1_data", i), rsp1_data, i + 100);
    end
    check("alt_cnt0", cnt0, 32'd3);
    check("alt_cnt1", cnt1, 32'd3);

    // Backpressure on port 0
    rsp0_ready = 1'b0;
    drive0(1'b1, 4'd4, 32'hFFFF_FFF0, 32'd2);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("bp_sra_req0_ready", req0_ready, 32'd1);
    tick();
    check("bp_sra_rsp0_valid", rsp0_valid, 32'd1);
    check("bp_sra_rsp0_data", rsp0_data, 32'hFFFF_FFFC);
    for (int k = 1; k <= 3; k++) begin
      drive0(1'b1, 4'd0, 32'd1, 32'd1);
      drive1(1'b1, 4'd0, k, k);
      #1;
      check($sformatf("bp%0d_req0_ready", k), req0_ready, 32'd0);
      check($sformatf("bp%0d_req1_ready", k), req1_ready, 32'd1);
      tick();
      check($sformatf("bp%0d_rsp0_hold", k), rsp0_data, 32'hFFFF_FFFC);
      check($sformatf("bp%0d_rsp1_data", k), rsp1_data, 2 * k);
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_req0_ready", req0_ready, 32'd1);
    check("bp_release_req1_ready", req1_ready, 32'd0);
    tick();
    check("bp_release_rsp0_data", rsp0_data, 32'd2);

    // Idle
    drive0(1'b0, 4'd0, 32'd9, 32'd9);
    drive1(1'b0, 4'd0, 32'd9, 32'd9);
    #1;
    check("idle_alu_sel", alu_sel, 32'd10);
    check("idle_alu_a", alu_a, 32'd0);
    check("idle_alu_b", alu_b, 32'd0);
    tick();
    check("idle_rsp0_drained", rsp0_valid, 32'd0);
    check("idle_rsp0_hold", rsp0_data, 32'd2);

    // Signed / unsigned compare and an undefined op on port 1
    drive1(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt_rsp1_data", rsp1_data, 32'd1);
    drive1(1'b1, 4'd6, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("sltu_rsp1_data", rsp1_data, 32'd0);
    drive1(1'b1, 4'd7, 32'h0000_00F0, 32'h0000_000F);
    tick();
    check("xor_rsp1_data", rsp1_data, 32'h0000_00FF);
    drive1(1'b1, 4'd12, 32'd3, 32'd4);
    #1;
    check("op12_req1_ready", req1_ready, 32'd1);
    tick();
    check("op12_rsp1_valid", rsp1_valid, 32'd1);
    check("op12_rsp1_data", rsp1_data, 32'd0);
    drive1(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset mid-operation
    rsp0_ready = 1'b0;
    drive0(1'b1, 4'd0, 32'd2, 32'd3);
    tick();
    check("mid_rsp0_valid", rsp0_valid, 32'd1);
    check("mid_rsp0_data", rsp0_data, 32'd5);
    drive0(1'b0, 4'd0, 32'd0, 32'd0);
    drive1(1'b1, 4'd0, 32'd4, 32'd4);
    rst = 1'b1;
    #1;
    check("mid_req1_ready", req1_ready, 32'd1);
    tick();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    check("mid_rst_rsp0_valid", rsp0_valid, 32'd0);
    check("mid_rst_rsp1_valid", rsp1_valid, 32'd0);
    check("mid_rst_rsp0_data", rsp0_data, 32'd0);
    check("mid_rst_rsp1_data", rsp1_data, 32'd0);
    drive0(1'b1, 4'd8, 32'd1, 32'd2);
    drive1(1'b1, 4'd9, 32'd3, 32'd1);
    #1;
    check("post_rst_req0_ready", req0_ready, 32'd1);
    check("post_rst_req1_ready", req1_ready, 32'd0);
    tick();
    check("post_rst_rsp0_data", rsp0_data, 32'd3);
    #1;
    check("post_rst_req1_next", req1_ready, 32'd1);
    tick();
    check("post_rst_rsp1_data", rsp1_data, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: port 0 is the execute stage, port 1 is the address-generation / auxiliary unit.
- Round-robin arbitration with valid/ready handshakes on the request and response sides.
- Drives the ALU select and operands, then registers each result into a one-entry response slot per requester.
- Sits between the pipeline control and the shared ALU, so the datapath needs only one adder/shifter.

Parameters:
- DATAW, 32, operand and result width; must match the ALU's IDATAW/ODATAW.
- NOP_SEL, 4'd10, ALU select driven when no request is granted; the ALU passes operand b for this code.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when high with valid
- req0_op  in  4  ALU select (0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 SLT, 6 SLTU, 7 XOR, 8 OR, 9 AND, 10 NOP)
- req0_a  in  DATAW  operand 1, signed
- req0_b  in  DATAW  operand 2, signed
- rsp0_valid  out  1  port 0 result valid
- rsp0_ready  in  1  port 0 consumer takes the result
- rsp0_data  out  DATAW  port 0 result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1
- alu_sel  out  4  to ALU alu_sel
- alu_a  out  DATAW  to ALU idata1
- alu_b  out  DATAW  to ALU idata2
- alu_result  in  DATAW  from ALU odata, combinational

Behaviour:
- Reset (synchronous; rst sampled at a rising edge):
  - rsp0_valid = rsp1_valid = 0; rsp0_data = rsp1_data = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - A reset asserted mid-operation discards pending results and any request in flight; requesters re-present after reset.
- Slot availability: slotN_free = !rspN_valid || rspN_ready (a drain and a refill can happen in the same cycle).
- Eligibility: eligN = reqN_valid && slotN_free.
- Arbitration (combinational, one grant per cycle):
  - Only elig0 → grant 0; only elig1 → grant 1.
  - Both → grant the port != last_grant.
  - Neither → no grant.
- reqN_ready = grantN. Ready may depend on valid; a requester's valid must never depend on its ready.
- ALU drive:
  - Granted port's op, a and b go to alu_sel, alu_a, alu_b.
  - No grant → alu_sel = NOP_SEL, alu_a = 0, alu_b = 0.
- Capture:
  - On a clock edge with grantN: rspN_data <= alu_result, rspN_valid <= 1, last_grant <= N.
  - Without grantN: if rspN_valid && rspN_ready, rspN_valid <= 0 and rspN_data holds its last value.
- Latency: the result is visible exactly 1 cycle after acceptance. Throughput is one op per cycle total.
- Backpressure: while rspN_valid && !rspN_ready, port N is not granted. The other port keeps full service and takes every cycle, even if it was last granted.
- Ordering: results per port are in request order (one slot, no reordering). No ordering between ports.
- Ops 11–15 pass through unchanged; the ALU returns 0 and the arbiter raises rspN_valid normally.
- Requesters hold op/a/b stable while valid && !ready. Changing them before acceptance is legal; whatever is present in the accept cycle is used.
- Fairness: with both ports continuously eligible, grants strictly alternate.
- last_grant updates only on a grant. Idle cycles preserve it.

Test Plan:
- Single op: after reset, req0 ADD a=5 b=7 for one cycle → req0_ready=1, alu_sel=0 that cycle; next cycle rsp0_valid=1, rsp0_data=12.
- Contention after reset: req0 SUB 10,3 and req1 SLL 1,4 both valid, rsp readies high.
  - cycle0: grant 0.
  - cycle1: rsp0_data=7, grant 1.
  - cycle2: rsp1_data=16.
- Alternation: both ports valid with ADD for 6 cycles, responses always ready → grants 0,1,0,1,0,1; each port gets 3 results.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 holding SRA(-16,2) = -4, req0 and req1 both valid.
  - req0_ready stays 0; port 1 is granted every cycle; rsp0_data holds 0xFFFFFFFC.
  - On rsp0_ready=1, port 0 is granted that same cycle.
- Idle and signed ops:
  - No valids → alu_sel=10, alu_a=0, alu_b=0, no rsp change.
  - req1 SLT(-1,1) → rsp1_data=1.
  - req1 SLTU(-1,1) → rsp1_data=0.
- Reset mid-operation: rsp0_valid=1 and req1 accepted in the same cycle as rst=1 → next cycle rsp0_valid=0, rsp1_valid=0, data=0; first post-reset contention grants port 0.
